// File: rtl/shifter8_pkg.sv
// Shared encodings for the 8-bit shifter datapath and its sequencing controller:
// shifter op codes, request op codes, controller FSM states.
package shifter8_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_LSL  = 3'b010;
  localparam logic [2:0] OP_LSR  = 3'b011;
  localparam logic [2:0] OP_ASR  = 3'b100;

  localparam logic [1:0] REQ_LSL  = 2'b00;
  localparam logic [1:0] REQ_LSR  = 2'b01;
  localparam logic [1:0] REQ_ASR  = 2'b10;
  localparam logic [1:0] REQ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // Translate a request op into the shifter op issued on every shift step.
  function automatic logic [2:0] req_to_shift_op(input logic [1:0] req_op);
    logic [2:0] op;
    case (req_op)
      REQ_LSL: op = OP_LSL;
      REQ_LSR: op = OP_LSR;
      REQ_ASR: op = OP_ASR;
      default: op = OP_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/shifter8_seq_ctrl.sv
// Sequencing controller for one shifter8: accepts a shift request, issues LOAD
// plus greedy shift steps of at most STEP_MAX, then holds the result until taken.
module shifter8_seq_ctrl
  import shifter8_pkg::*;
#(
  parameter int STEP_MAX = 3,
  parameter int AMT_W    = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [AMT_W-1:0] req_amt,
  input  logic [7:0]       req_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic             res_err,
  output logic             busy,
  output logic [2:0]       sh_op,
  output logic [1:0]       sh_shamt,
  output logic [7:0]       sh_d_in,
  input  logic [7:0]       sh_d_out
);

  localparam logic [AMT_W-1:0] STEP_W = AMT_W'(STEP_MAX);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic [7:0]       data_q, data_d;
  logic             err_q, err_d;
  logic [AMT_W-1:0] step_s;

  // Greedy split: full STEP_MAX steps while more remains, the remainder last.
  assign step_s = (amt_q > STEP_W) ? STEP_W : amt_q;

  // State and captured-request registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= 2'b00;
      amt_q   <= '0;
      data_q  <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      amt_q   <= amt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Next-state and capture logic.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    amt_d   = amt_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          data_d  = req_data;
          state_d = ST_LOAD;
          if (req_op == REQ_RSVD) begin
            amt_d = '0;
            err_d = 1'b1;
          end else begin
            amt_d = req_amt;
            err_d = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (amt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // step_s never exceeds amt_q, so remaining cannot underflow.
        amt_d = amt_q - step_s;
        if (amt_q == step_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore output decode from state and captured registers only.
  always_comb begin
    req_ready = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    sh_op     = OP_NOP;
    sh_shamt  = 2'b00;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_LOAD: begin
        sh_op = OP_LOAD;
      end
      ST_SHIFT: begin
        sh_op    = req_to_shift_op(op_q);
        sh_shamt = step_s[1:0];
      end
      ST_DONE: begin
        res_valid = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  assign sh_d_in  = data_q;
  assign res_data = sh_d_out;
  assign res_err  = err_q;

endmodule

// File: tb/tb_shifter8_seq_ctrl.sv
// Scoreboard bench for shifter8_seq_ctrl: a behavioural shifter closes the loop,
// results come from a whole-amount reference shift, a monitor checks every output.
module tb_shifter8_seq_ctrl;

  localparam logic [2:0] T_NOP  = 3'd0;
  localparam logic [2:0] T_LOAD = 3'd1;
  localparam logic [2:0] T_LSL  = 3'd2;
  localparam logic [2:0] T_LSR  = 3'd3;
  localparam logic [2:0] T_ASR  = 3'd4;

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         acc;
    int         lat;
  } exp_t;

  typedef struct {
    logic [2:0] op;
    logic [1:0] shamt;
    logic [7:0] d;
  } opexp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid, req_ready;
  logic [1:0] req_op;
  logic [2:0] req_amt;
  logic [7:0] req_data;
  logic       res_valid, res_ready, res_err, busy;
  logic [7:0] res_data;
  logic [2:0] sh_op;
  logic [1:0] sh_shamt;
  logic [7:0] sh_d_in, sh_d_out;
  logic [7:0] sh_reg;
  logic       rr_auto = 1'b0, rr_man = 1'b0, rr_rand = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_hs = 0;
  int last_acc = 0;
  exp_t   sb_q[$];
  opexp_t op_q[$];

  always #5 clk = ~clk;

  shifter8_seq_ctrl #(.STEP_MAX(3), .AMT_W(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_amt(req_amt), .req_data(req_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err), .busy(busy),
    .sh_op(sh_op), .sh_shamt(sh_shamt), .sh_d_in(sh_d_in), .sh_d_out(sh_d_out)
  );

  // Behavioural shifter8 sharing the controller's reset.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) sh_reg <= 8'h00;
    else begin
      case (sh_op)
        T_LOAD:  sh_reg <= sh_d_in;
        T_LSL:   sh_reg <= sh_reg << sh_shamt;
        T_LSR:   sh_reg <= sh_reg >> sh_shamt;
        T_ASR:   sh_reg <= $signed(sh_reg) >>> sh_shamt;
        default: sh_reg <= sh_reg;
      endcase
    end
  end
  assign sh_d_out = sh_reg;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rr_rand = 1'($urandom_range(0, 1));
  end
  assign res_ready = rr_auto ? rr_rand : rr_man;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_result(input logic [1:0] op, input int amt,
                                            input logic [7:0] d);
    logic signed [7:0] s;
    s = d;
    case (op)
      2'd0:    return d << amt;
      2'd1:    return d >> amt;
      2'd2:    return 8'(s >>> amt);
      default: return d;
    endcase
  endfunction

  task automatic send(input logic [1:0] op, input int amt, input logic [7:0] d);
    exp_t   e;
    opexp_t o;
    int     eff, rem, n;
    bit     ok;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_amt = amt[2:0]; req_data = d;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    eff    = (op == 2'd3) ? 0 : amt;
    e.data = ref_result(op, amt, d);
    e.err  = (op == 2'd3);
    e.acc  = cyc + 1;
    e.lat  = 1 + (eff + 2) / 3;
    sb_q.push_back(e);
    o.op = T_LOAD; o.shamt = 2'd0; o.d = d;
    op_q.push_back(o);
    rem = eff;
    while (rem > 0) begin
      n = (rem > 3) ? 3 : rem;
      o.op    = (op == 2'd0) ? T_LSL : (op == 2'd1) ? T_LSR : T_ASR;
      o.shamt = n[1:0];
      op_q.push_back(o);
      rem -= n;
    end
    last_acc = cyc + 1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_data  = 8'($urandom);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !busy) ok = 1'b1;
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  // Monitor: checks issued shifter ops, result data/err/latency and DONE hold.
  bit         res_seen = 1'b0;
  logic [7:0] held_data;
  int         rise_cyc;
  exp_t       me;
  opexp_t     mo;
  always @(negedge clk) begin
    if (!reset_n) begin
      res_seen = 1'b0;
    end else begin
      if (sh_op != T_NOP) begin
        if (op_q.size() == 0) chk("unexpected_sh_op", sh_op, T_NOP);
        else begin
          mo = op_q.pop_front();
          chk("sh_op", sh_op, mo.op);
          if (mo.op == T_LOAD) chk("sh_d_in_load", sh_d_in, mo.d);
          else chk("sh_shamt", sh_shamt, mo.shamt);
        end
      end
      if (res_valid) begin
        if (!res_seen) begin
          res_seen  = 1'b1;
          held_data = res_data;
          rise_cyc  = cyc;
        end else begin
          chk("res_data_stable", res_data, held_data);
        end
        chk("done_req_ready", req_ready, 0);
        chk("done_sh_op", sh_op, T_NOP);
        if (res_ready) begin
          if (sb_q.size() == 0) chk("unexpected_result", 1, 0);
          else begin
            me = sb_q.pop_front();
            chk("res_data", res_data, me.data);
            chk("res_err", res_err, me.err);
            chk("latency", rise_cyc - me.acc, me.lat);
          end
          res_seen = 1'b0;
          last_hs  = cyc + 1;
        end
      end
    end
  end

  initial begin
    int ns;
    bit ok;
    reset_n = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_amt = 3'd0; req_data = 8'h00;
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sh_op", sh_op, T_NOP);
    chk("rst_sh_shamt", sh_shamt, 0);
    chk("rst_sh_d_in", sh_d_in, 0);
    #20 reset_n = 1'b1;
    rr_man = 1'b1;

    send(2'd2, 7, 8'h80); wait_idle();
    send(2'd0, 5, 8'h01); wait_idle();
    send(2'd1, 0, 8'hA5);
    send(2'd1, 3, 8'h5C);
    chk("back_to_back_gap", last_acc - last_hs, 1);
    wait_idle();

    // Backpressure with a stray request pulse while the result is held.
    rr_man = 1'b0;
    send(2'd1, 2, 8'hF0);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (res_valid) ok = 1'b1;
    end
    if (!ok) chk("bp_valid_timeout", 0, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      req_valid = (i == 1); req_op = 2'd0; req_amt = 3'd1;
      @(negedge clk);
      chk("bp_res_valid", res_valid, 1);
      chk("bp_res_data", res_data, 8'h3C);
    end
    rr_man = 1'b1;
    wait_idle();
    repeat (3) begin
      @(negedge clk);
      chk("bp_ignored_busy", busy, 0);
    end

    // Reset during the second shift step of an amt=6 LSL.
    send(2'd0, 6, 8'h03);
    ns = 0;
    for (int i = 0; i < 20 && ns < 2; i++) begin
      @(negedge clk);
      if (sh_op == T_LSL) ns++;
    end
    chk("second_shift_seen", ns, 2);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_sh_op", sh_op, T_NOP);
    sb_q.delete();
    op_q.delete();
    #15 reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", req_ready, 1);
    send(2'd0, 6, 8'h03); wait_idle();

    send(2'd3, 4, 8'h5A); wait_idle();
    chk("err_cleared", res_err, 0);

    rr_auto = 1'b1;
    for (int k = 0; k < 150; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(2'($urandom_range(0, 3)), int'($urandom_range(0, 7)), 8'($urandom));
    end
    wait_idle();
    rr_auto = 1'b0;
    chk("sb_empty", sb_q.size(), 0);
    chk("opq_empty", op_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
